// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready request front end for a single-port synchronous SRAM.
// Build option SRAM_REQ_ADAPTER_RANGE_CHECK_EN: out-of-range addresses get an immediate error response.
module sram_req_adapter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [NUM_WMASKS-1:0]   mask_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    accept;

`ifdef SRAM_REQ_ADAPTER_RANGE_CHECK_EN
    logic err_q;
    logic range_err;
    logic unused_addr;
    assign range_err   = |req_addr[31:ADDR_WIDTH+2];
    assign rsp_err     = err_q;
    assign unused_addr = ^req_addr[1:0];
`else
    // Upper address bits are dropped so accesses wrap modulo the RAM depth.
    logic unused_addr;
    assign rsp_err     = 1'b0;
    assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
`endif

    always_comb begin
        state_d    = state_q;
        req_ready  = (state_q == IDLE);
        accept     = req_valid && (state_q == IDLE);
        rsp_valid  = (state_q == RESP);
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef SRAM_REQ_ADAPTER_RANGE_CHECK_EN
                    state_d = range_err ? RESP : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                sram_csb   = 1'b0;
                sram_web   = !write_q;
                sram_wmask = mask_q;
            end
            WAIT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sram_addr = addr_q;
    assign sram_din  = wdata_q;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
`ifdef SRAM_REQ_ADAPTER_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                wdata_q <= req_wdata;
                mask_q  <= req_mask;
                addr_q  <= req_addr[ADDR_WIDTH+1:2];
                rdata_q <= '0;
`ifdef SRAM_REQ_ADAPTER_RANGE_CHECK_EN
                err_q   <= range_err;
`endif
            end
            // SRAM output is valid one cycle after the ISSUE edge, i.e. while in WAIT.
            if (state_q == WAIT) begin
                rdata_q <= write_q ? '0 : sram_dout;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter: directed and randomized requests checked against a byte-lane memory model.
`timescale 1ns/1ps
module tb_sram_req_adapter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NM = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NM-1:0] req_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sram_csb;
  logic          sram_web;
  logic [NM-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram_mem [256];
  logic [31:0] ref_mem  [256];

  always #5 clock = ~clock;

  sram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Synchronous SRAM: samples controls at posedge, read data appears after that edge.
  always @(posedge clock) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int unsigned i = 0; i < NM; i++)
          if (sram_wmask[i]) sram_mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] mk, input int stall, output logic [31:0] got);
    bit          is_err;
    logic [7:0]  word;
    logic [31:0] exp_rd;
    logic [31:0] held_rd;
    logic        held_err;
    int          lat;
    int          lows;
    int          exp_lat;
    int          exp_lows;
    word = addr[9:2];
`ifdef SRAM_REQ_ADAPTER_RANGE_CHECK_EN
    is_err = (addr[31:10] != 0);
`else
    is_err = 1'b0;
`endif
    exp_rd = (wr || is_err) ? 32'h0 : ref_mem[word];
    exp_lat = is_err ? 1 : 3;
    exp_lows = is_err ? 0 : 1;
    @(negedge clock);
    check("idle_req_ready", req_ready === 1'b1, 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_mask = mk;
    @(posedge clock); #1;
    lat = 0; lows = 0;
    do begin
      @(negedge clock);
      lat++;
      if (!sram_csb) begin
        lows++;
        check("issue_web", sram_web === !wr, 64'(sram_web), 64'(!wr));
        check("issue_addr", sram_addr === word, 64'(sram_addr), 64'(word));
        if (wr) begin
          check("issue_din", sram_din === wd, 64'(sram_din), 64'(wd));
          check("issue_wmask", sram_wmask === mk, 64'(sram_wmask), 64'(mk));
        end
      end
      if (!rsp_valid) begin
        check("busy_req_ready", req_ready === 1'b0, 64'(req_ready), 64'(1'b0));
        req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_mask = 4'($urandom); rsp_ready = 1'($urandom);
      end
    end while (!rsp_valid && lat < 20);
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("latency", lat === exp_lat, 64'(lat), 64'(exp_lat));
    check("csb_cycles", lows === exp_lows, 64'(lows), 64'(exp_lows));
    check("rsp_rdata", rsp_rdata === exp_rd, 64'(rsp_rdata), 64'(exp_rd));
    check("rsp_err", rsp_err === is_err, 64'(rsp_err), 64'(is_err));
    check("sram_quiet", {sram_csb, sram_web, sram_wmask} === 6'b110000,
          64'({sram_csb, sram_web, sram_wmask}), 64'(6'b110000));
    got = rsp_rdata;
    held_rd = rsp_rdata; held_err = rsp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check("stall_valid", rsp_valid === 1'b1, 64'(rsp_valid), 64'(1'b1));
      check("stall_rdata", rsp_rdata === held_rd, 64'(rsp_rdata), 64'(held_rd));
      check("stall_err", rsp_err === held_err, 64'(rsp_err), 64'(held_err));
      check("stall_req_ready", req_ready === 1'b0, 64'(req_ready), 64'(1'b0));
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("single_response", rsp_valid === 1'b0, 64'(rsp_valid), 64'(1'b0));
    check("ready_after", req_ready === 1'b1, 64'(req_ready), 64'(1'b1));
    if (wr && !is_err)
      for (int unsigned i = 0; i < 4; i++)
        if (mk[i]) ref_mem[word][8*i +: 8] = wd[8*i +: 8];
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          stale;

    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready === 1'b1, 64'(req_ready), 64'(1'b1));
    check("rst_rsp_valid", rsp_valid === 1'b0, 64'(rsp_valid), 64'(1'b0));
    check("rst_rsp_rdata", rsp_rdata === 32'h0, 64'(rsp_rdata), 64'(32'h0));
    check("rst_rsp_err", rsp_err === 1'b0, 64'(rsp_err), 64'(1'b0));
    check("rst_sram_ctl", {sram_csb, sram_web, sram_wmask} === 6'b110000,
          64'({sram_csb, sram_web, sram_wmask}), 64'(6'b110000));
    check("rst_sram_addr", sram_addr === 8'h0, 64'(sram_addr), 64'(8'h0));
    check("rst_sram_din", sram_din === 32'h0, 64'(sram_din), 64'(32'h0));
    reset = 1'b0;

    for (int unsigned w = 0; w < 256; w++)
      do_req(1'b1, {22'h0, 8'(w), 2'($urandom)}, $urandom, 4'hF, 0, got);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
    check("wr_rdata_zero", got === 32'h0, 64'(got), 64'(32'h0));
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    check("rd_deadbeef", got === 32'hDEADBEEF, 64'(got), 64'(32'hDEADBEEF));

    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1, got);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 2, got);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    check("rd_masked_merge", got === 32'h11BB33DD, 64'(got), 64'(32'h11BB33DD));
    do_req(1'b1, 32'h22, 32'hFFFFFFFF, 4'h0, 0, got);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    check("rd_after_mask0", got === 32'h11BB33DD, 64'(got), 64'(32'h11BB33DD));

    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, 4, got);

    do_req(1'b0, 32'h400, 32'h0, 4'h0, 1, got);
`ifdef SRAM_REQ_ADAPTER_RANGE_CHECK_EN
    check("oor_rdata", got === 32'h0, 64'(got), 64'(32'h0));
`else
    check("alias_word0", got === ref_mem[0], 64'(got), 64'(ref_mem[0]));
`endif

    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("mid_issue_csb", sram_csb === 1'b0, 64'(sram_csb), 64'(1'b0));
    @(negedge clock);
    check("mid_wait", {rsp_valid, sram_csb, req_ready} === 3'b010,
          64'({rsp_valid, sram_csb, req_ready}), 64'(3'b010));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("post_rst_rsp_valid", rsp_valid === 1'b0, 64'(rsp_valid), 64'(1'b0));
    check("post_rst_csb", sram_csb === 1'b1, 64'(sram_csb), 64'(1'b1));
    check("post_rst_req_ready", req_ready === 1'b1, 64'(req_ready), 64'(1'b1));
    stale = 0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid) stale++;
    end
    check("no_stale_rsp", stale === 0, 64'(stale), 64'(0));

    @(negedge clock);
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0;
    check("rst_prio_ready", req_ready === 1'b1, 64'(req_ready), 64'(1'b1));
    check("rst_prio_csb", sram_csb === 1'b1, 64'(sram_csb), 64'(1'b1));

    for (int unsigned n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
